// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Moore control sequencer for the multicycle MIPS datapath
//               (fetch/decode/execute/memory/writeback). Optional performance
//               counters are built when MULTICYCLE_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int ALU_W         = 5,
    parameter int RESET_PC_HOLD = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pcEn,
    output logic             IorD,
    output logic             IRWrite,
    output logic             memWrite,
    output logic             memToReg,
    output logic             regDst,
    output logic             regWriteEnable,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic             jumpReg,
    output logic [ALU_W-1:0] ALUControl,
    output logic             illegal,
    output logic [31:0]      perfCycles,
    output logic [31:0]      perfInstrs
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;
    localparam logic [5:0] c_FN_JR  = 6'b001000;

    localparam logic [ALU_W-1:0] c_ALU_ADD = ALU_W'(5'b00010);
    localparam logic [ALU_W-1:0] c_ALU_SUB = ALU_W'(5'b00110);
    localparam logic [ALU_W-1:0] c_ALU_AND = ALU_W'(5'b00000);
    localparam logic [ALU_W-1:0] c_ALU_OR  = ALU_W'(5'b00001);
    localparam logic [ALU_W-1:0] c_ALU_SLT = ALU_W'(5'b00111);

    // Last hold-counter value seen in IDLE before moving on to FETCH.
    localparam logic [3:0] c_HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JR       = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_hold;
    logic             w_funct_ok;
    logic [ALU_W-1:0] w_alu_rtype;

    // R-type funct decode; JR is handled separately by the opcode decode.
    always_comb begin : p_funct_decode
        w_funct_ok  = 1'b1;
        w_alu_rtype = c_ALU_ADD;
        case (funct)
            c_FN_ADD: w_alu_rtype = c_ALU_ADD;
            c_FN_SUB: w_alu_rtype = c_ALU_SUB;
            c_FN_AND: w_alu_rtype = c_ALU_AND;
            c_FN_OR:  w_alu_rtype = c_ALU_OR;
            c_FN_SLT: w_alu_rtype = c_ALU_SLT;
            default:  w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin : p_next_state
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_hold == c_HOLD_LAST) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE: begin
                        if (funct == c_FN_JR) begin
                            w_next = S_JR;
                        end else if (w_funct_ok) begin
                            w_next = S_RTYPE_EX;
                        end else begin
                            w_next = S_ILLEGAL;
                        end
                    end
                    c_OP_BEQ:  w_next = S_BRANCH;
                    c_OP_ADDI: w_next = S_ADDI_EX;
                    c_OP_J:    w_next = S_JUMP;
                    default:   w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    w_next = S_MEMWB;
            S_RTYPE_EX: w_next = S_RTYPE_WB;
            S_ADDI_EX:  w_next = S_ADDI_WB;
            S_MEMWB, S_MEMWR, S_RTYPE_WB, S_ADDI_WB,
            S_BRANCH, S_JUMP, S_JR: w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin : p_state
        if (reset) begin
            r_state <= S_IDLE;
            r_hold  <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_IDLE) begin
                r_hold <= r_hold + 4'd1;
            end
        end
    end

    // Outputs decode the current state; reset overrides everything so an
    // abandoned instruction can never leave a write strobe asserted.
    always_comb begin : p_outputs
        pcEn           = 1'b0;
        IorD           = 1'b0;
        IRWrite        = 1'b0;
        memWrite       = 1'b0;
        memToReg       = 1'b0;
        regDst         = 1'b0;
        regWriteEnable = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'b00;
        PCSrc          = 2'b00;
        jumpReg        = 1'b0;
        ALUControl     = '0;
        illegal        = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    IRWrite    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUControl = c_ALU_ADD;
                    pcEn       = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = c_ALU_ADD;
                end
                S_MEMADR, S_ADDI_EX: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = c_ALU_ADD;
                end
                S_MEMRD: begin
                    IorD       = 1'b1;
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = c_ALU_ADD;
                end
                S_MEMWB: begin
                    regWriteEnable = 1'b1;
                    memToReg       = 1'b1;
                end
                S_MEMWR: begin
                    IorD       = 1'b1;
                    memWrite   = 1'b1;
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = c_ALU_ADD;
                end
                S_RTYPE_EX: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = w_alu_rtype;
                end
                S_RTYPE_WB: begin
                    ALUSrcA        = 1'b1;
                    ALUControl     = w_alu_rtype;
                    regWriteEnable = 1'b1;
                    regDst         = 1'b1;
                end
                S_ADDI_WB: begin
                    ALUSrcA        = 1'b1;
                    ALUSrcB        = 2'b10;
                    ALUControl     = c_ALU_ADD;
                    regWriteEnable = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = c_ALU_SUB;
                    PCSrc      = 2'b01;
                    pcEn       = zero;
                end
                S_JUMP: begin
                    PCSrc = 2'b10;
                    pcEn  = 1'b1;
                end
                S_JR: begin
                    PCSrc   = 2'b10;
                    jumpReg = 1'b1;
                    pcEn    = 1'b1;
                end
                S_ILLEGAL: illegal = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_instrs;

    always_ff @(posedge clock) begin : p_perf
        if (reset) begin
            r_perf_cycles <= 32'd0;
            r_perf_instrs <= 32'd0;
        end else begin
            if (r_state != S_IDLE && r_state != S_ILLEGAL) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            // Only an instruction's final state returns to FETCH.
            if (w_next == S_FETCH && r_state != S_IDLE) begin
                r_perf_instrs <= r_perf_instrs + 32'd1;
            end
        end
    end

    assign perfCycles = reset ? 32'd0 : r_perf_cycles;
    assign perfInstrs = reset ? 32'd0 : r_perf_instrs;
`else
    assign perfCycles = 32'd0;
    assign perfInstrs = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// Randomized instruction stream against an instruction-level reference model
// of the multicycle control sequencer, plus directed literal checks.
module tb_multicycle_control_fsm;

    localparam int HOLD = 1;

    localparam logic [4:0] A_ADD = 5'b00010;
    localparam logic [4:0] A_SUB = 5'b00110;
    localparam logic [4:0] A_AND = 5'b00000;
    localparam logic [4:0] A_OR  = 5'b00001;
    localparam logic [4:0] A_SLT = 5'b00111;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_ADDI = 3, C_BEQ = 4,
                   C_J = 5, C_JR = 6, C_ILL = 7;
    localparam int M_IDLE = 0, M_RUN = 1, M_ILL = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        pcEn, IorD, IRWrite, memWrite, memToReg, regDst;
    logic        regWriteEnable, ALUSrcA, jumpReg, illegal;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [4:0]  ALUControl;
    logic [31:0] perfCycles, perfInstrs;
    logic [18:0] dut_bus;

    multicycle_control_fsm #(.ALU_W(5), .RESET_PC_HOLD(HOLD)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pcEn(pcEn), .IorD(IorD), .IRWrite(IRWrite), .memWrite(memWrite),
        .memToReg(memToReg), .regDst(regDst), .regWriteEnable(regWriteEnable),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .jumpReg(jumpReg),
        .ALUControl(ALUControl), .illegal(illegal),
        .perfCycles(perfCycles), .perfInstrs(perfInstrs)
    );

    always #5 clock = ~clock;

    // Bit map: 18 pcEn,17 IorD,16 IRWrite,15 memWrite,14 memToReg,13 regDst,
    // 12 regWE,11 ALUSrcA,10:9 ALUSrcB,8:7 PCSrc,6 jumpReg,5:1 ALUControl,0 illegal
    assign dut_bus = {pcEn, IorD, IRWrite, memWrite, memToReg, regDst, regWriteEnable,
                      ALUSrcA, ALUSrcB, PCSrc, jumpReg, ALUControl, illegal};

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h04: return C_BEQ;
            6'h08: return C_ADDI;
            6'h02: return C_J;
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: return C_R;
                    6'h08: return C_JR;
                    default: return C_ILL;
                endcase
            end
            default: return C_ILL;
        endcase
    endfunction

    function automatic int len_of(input int c);
        case (c)
            C_LW: return 5;
            C_SW, C_R, C_ADDI: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20: return A_ADD;
            6'h22: return A_SUB;
            6'h24: return A_AND;
            6'h25: return A_OR;
            6'h2a: return A_SLT;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [18:0] pk(input logic pc, iord, irw, mw, m2r, rd, rwe, sa,
                                       input logic [1:0] sb, ps, input logic jr,
                                       input logic [4:0] alu, input logic ill);
        return {pc, iord, irw, mw, m2r, rd, rwe, sa, sb, ps, jr, alu, ill};
    endfunction

    // Reference model: which instruction is in flight and how many cycles in.
    int m_mode = M_IDLE;
    int m_idle = 0;
    int m_step = 0;
    int m_cls  = C_ILL;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ins = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_mode = M_IDLE; m_idle = 0; m_cyc = 0; m_ins = 0;
        end else if (m_mode == M_IDLE) begin
            m_idle++;
            if (m_idle >= HOLD) begin m_mode = M_RUN; m_step = 0; end
        end else if (m_mode == M_RUN) begin
            m_cyc++;
            if (m_step == 1) begin
                m_cls = classify(opcode, funct);
                if (m_cls == C_ILL) m_mode = M_ILL;
            end
            if (m_mode == M_RUN) begin
                m_step++;
                if (m_step == len_of(m_cls)) begin m_step = 0; m_ins++; end
            end
        end
    end

    function automatic logic [18:0] expect_bus();
        if (reset || m_mode == M_IDLE) return 19'd0;
        if (m_mode == M_ILL) return 19'd1;
        if (m_step == 0) return pk(1,0,1,0,0,0,0,0,2'b01,2'b00,0,A_ADD,0);
        if (m_step == 1) return pk(0,0,0,0,0,0,0,0,2'b11,2'b00,0,A_ADD,0);
        case (m_cls)
            C_LW: begin
                if (m_step == 2) return pk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,A_ADD,0);
                if (m_step == 3) return pk(0,1,0,0,0,0,0,1,2'b10,2'b00,0,A_ADD,0);
                return pk(0,0,0,0,1,0,1,0,2'b00,2'b00,0,5'b0,0);
            end
            C_SW: begin
                if (m_step == 2) return pk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,A_ADD,0);
                return pk(0,1,0,1,0,0,0,1,2'b10,2'b00,0,A_ADD,0);
            end
            C_R: begin
                if (m_step == 2) return pk(0,0,0,0,0,0,0,1,2'b00,2'b00,0,alu_of(funct),0);
                return pk(0,0,0,0,0,1,1,1,2'b00,2'b00,0,alu_of(funct),0);
            end
            C_ADDI: begin
                if (m_step == 2) return pk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,A_ADD,0);
                return pk(0,0,0,0,0,0,1,1,2'b10,2'b00,0,A_ADD,0);
            end
            C_BEQ:   return pk(zero,0,0,0,0,0,0,1,2'b00,2'b01,0,A_SUB,0);
            C_J:     return pk(1,0,0,0,0,0,0,0,2'b00,2'b10,0,5'b0,0);
            default: return pk(1,0,0,0,0,0,0,0,2'b00,2'b10,1,5'b0,0);
        endcase
    endfunction

    always @(negedge clock) begin
        logic [31:0] exp_pc, exp_pi;
`ifdef MULTICYCLE_PERF_CNT_EN
        exp_pc = reset ? 32'd0 : m_cyc;
        exp_pi = reset ? 32'd0 : m_ins;
`else
        exp_pc = 32'd0;
        exp_pi = 32'd0;
`endif
        check("model_bus", {13'd0, dut_bus}, {13'd0, expect_bus()});
        check("model_perfCycles", perfCycles, exp_pc);
        check("model_perfInstrs", perfInstrs, exp_pi);
    end

    logic [18:0] cap [0:15];
    logic [31:0] cap_pc, cap_pi;

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    // Called in the FETCH cycle; drives one instruction for len cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int z,
                             input int len, input bit garb);
        for (int k = 0; k < len; k++) begin
            if (k == 0 && garb) begin
                opcode = 6'($urandom); funct = 6'($urandom);
            end else begin
                opcode = op; funct = fn;
            end
            zero = (z < 0) ? 1'($urandom) : z[0];
            @(negedge clock);
            cap[k] = dut_bus;
            if (k == 0) begin cap_pc = perfCycles; cap_pi = perfInstrs; end
            nxt();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) nxt();
        reset = 1'b0;
        repeat (HOLD) nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        logic [5:0] rfn [0:4];
        int r;
        rfn[0] = 6'h20; rfn[1] = 6'h22; rfn[2] = 6'h24; rfn[3] = 6'h25; rfn[4] = 6'h2a;

        repeat (3) begin
            @(negedge clock);
            check("reset_outputs_zero", {13'd0, dut_bus}, 32'd0);
            nxt();
        end
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs_zero", {13'd0, dut_bus}, 32'd0);
        nxt();

        run_instr(6'h23, 6'h00, 0, 5, 0);
        check("fetch_irw_pcen_srcb", {28'd0, cap[0][18], cap[0][16], cap[0][10:9]}, 32'b1101);
        check("lw_memrd_iord_no_rwe", {30'd0, cap[3][17], cap[3][12]}, 32'b10);
        check("lw_memwb_m2r_rwe", {30'd0, cap[4][14], cap[4][12]}, 32'b11);
        run_instr(6'h00, 6'h20, -1, 4, 0);
        check("add_ex_alu", {27'd0, cap[2][5:1]}, 32'b00010);
        run_instr(6'h04, 6'h00, 1, 3, 0);
        check("beq_taken_pcen_pcsrc", {29'd0, cap[2][18], cap[2][8:7]}, 32'b101);
        run_instr(6'h2b, 6'h00, -1, 4, 0);
`ifdef MULTICYCLE_PERF_CNT_EN
        check("perf_instrs_lw_add_beq", cap_pi, 32'd3);
        check("perf_cycles_lw_add_beq", cap_pc, 32'd12);
`else
        check("perf_instrs_tied_zero", cap_pi, 32'd0);
        check("perf_cycles_tied_zero", cap_pc, 32'd0);
`endif
        check("sw_memwr_iord_mw_rwe", {29'd0, cap[3][17], cap[3][15], cap[3][12]}, 32'b110);
        run_instr(6'h00, 6'h22, -1, 4, 0);
        check("sub_ex_alu", {27'd0, cap[2][5:1]}, 32'b00110);
        check("sub_wb_alu_rdst_rwe", {25'd0, cap[3][5:1], cap[3][13], cap[3][12]}, 32'b0011011);
        run_instr(6'h04, 6'h00, 0, 3, 0);
        check("beq_not_taken_pcen_pcsrc", {29'd0, cap[2][18], cap[2][8:7]}, 32'b001);
        run_instr(6'h00, 6'h08, -1, 3, 0);
        check("fetch_after_beq_irw", {31'd0, cap[0][16]}, 32'd1);
        check("jr_pcen_pcsrc_jumpreg", {28'd0, cap[2][18], cap[2][8:7], cap[2][6]}, 32'b1101);
        run_instr(6'h3f, 6'h00, -1, 12, 0);
        for (int k = 2; k < 12; k++) check("illegal_held", {13'd0, cap[k]}, 32'd1);

        do_reset(2);
        run_instr(6'h23, 6'h00, -1, 3, 0);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_memrd_outputs_zero", {13'd0, dut_bus}, 32'd0);
        nxt();
        reset = 1'b0;
        @(negedge clock);
        check("midrst_perf_cleared", perfCycles | perfInstrs, 32'd0);
        repeat (HOLD) nxt();

        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15)      run_instr(6'h23, 6'h00, -1, 5, 1);
            else if (r < 27) run_instr(6'h2b, 6'h00, -1, 4, 1);
            else if (r < 52) run_instr(6'h00, rfn[$urandom_range(0, 4)], -1, 4, 1);
            else if (r < 62) run_instr(6'h08, 6'($urandom), -1, 4, 1);
            else if (r < 74) run_instr(6'h04, 6'($urandom), -1, 3, 1);
            else if (r < 82) run_instr(6'h02, 6'($urandom), -1, 3, 1);
            else if (r < 90) run_instr(6'h00, 6'h08, -1, 3, 1);
            else if (r < 96) begin
                if (r < 94) begin
                    fn = 6'($urandom);
                    do op = 6'($urandom); while (op == 6'h00 || classify(op, fn) != C_ILL);
                end else begin
                    op = 6'h00;
                    do fn = 6'($urandom); while (classify(op, fn) != C_ILL);
                end
                run_instr(op, fn, -1, 2 + int'($urandom_range(1, 4)), 1);
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                run_instr(6'h23, 6'h00, -1, int'($urandom_range(1, 4)), 1);
                do_reset(int'($urandom_range(1, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style state machine that sequences the multicycle MIPS datapath: fetch, decode, execute, memory and writeback phases.
- Drives every datapath control line: PCWrite/IorD/IRWrite/ALUSrcA/ALUSrcB/PCSrc plus register-file, memory and ALU controls.
- Inputs: the instruction register opcode/funct fields and the ALU zero flag.
- Replaces the combinational decode used by the single-cycle datapath. Sits beside the datapath and is clocked by the same clock.

Parameters:
ALU_W, 5, width of ALUControl output
RESET_PC_HOLD, 1, cycles spent in IDLE after reset release before first FETCH (1..15)

Ports:
clock  input  1  system clock, all state changes on posedge
reset  input  1  synchronous, active-high; forces state IDLE
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU result == 0
pcEn  output  1  PC register enable (PCWrite | branch taken)
IorD  output  1  memory address select: 0 pcQ, 1 ALU result
IRWrite  output  1  instruction register load
memWrite  output  1  memory write enable
memToReg  output  1  WD3 select: 1 memory data, 0 ALU result
regDst  output  1  A3 select: 1 instr[15:11], 0 instr[20:16]
regWriteEnable  output  1  register file WE3
ALUSrcA  output  1  0 pcQ, 1 RDA
ALUSrcB  output  2  00 RDB, 01 constant 4, 10 SignImm, 11 SignImm<<2
PCSrc  output  2  00 ALU result, 01 ALU result (branch), 10 jump target
jumpReg  output  1  jump target = RD1 (jr) instead of {pc[31:28],instr[25:0],00}
ALUControl  output  5  00010 add, 00110 sub, 00000 and, 00001 or, 00111 slt
illegal  output  1  sticky: unsupported instruction decoded
perfCycles  output  32  cycle counter (see Optional Feature)
perfInstrs  output  32  retired-instruction counter (see Optional Feature)

Behaviour:
- Reset behaviour:
  - reset high at posedge → state IDLE, hold counter = 0, illegal = 0.
  - All outputs are forced 0 combinationally while reset is high. Reset mid-instruction abandons it with no write asserted.
- IDLE: all outputs 0. Stays RESET_PC_HOLD cycles, then goes to FETCH.
- FETCH:
  - IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00, pcEn=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUControl=add (branch target precompute). No writes.
  - Next state by opcode: 100011/101011 → MEMADR; 000000 → RTYPE_EX (funct 001000 → JR); 000100 → BRANCH; 001000 → ADDI_EX; 000010 → JUMP.
  - Any other opcode, or an R-type funct not in {100000,100010,100100,100101,101010,001000} → ILLEGAL.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, ALUSrcA=1, ALUSrcB=10, add (address held). Next state: MEMWB.
- MEMWB: regWriteEnable=1, memToReg=1, regDst=0. Next state: FETCH.
- MEMWR: IorD=1, memWrite=1, ALUSrcA=1, ALUSrcB=10, add. Next state: FETCH.
- RTYPE_EX:
  - ALUSrcA=1, ALUSrcB=00.
  - ALUControl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Next state: RTYPE_WB.
- RTYPE_WB: same ALU controls held, regWriteEnable=1, regDst=1, memToReg=0. Next state: FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, add. Next state: ADDI_WB.
- ADDI_WB: same ALU controls held, regWriteEnable=1, regDst=0, memToReg=0. Next state: FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, pcEn=zero.
  - The datapath must hold the branch target through this state.
  - Next state: FETCH.
- JUMP: PCSrc=10, jumpReg=0, pcEn=1. Next state: FETCH.
- JR: PCSrc=10, jumpReg=1, pcEn=1. Next state: FETCH.
- ILLEGAL: all outputs 0 except illegal=1. Stays in ILLEGAL until reset.
- Latency in cycles, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jr 3.
- Outputs are a pure decode of the state register, the opcode/funct fields and zero. Only pcEn depends on zero.
- Exactly one of {IRWrite, memWrite, regWriteEnable} may be high in any cycle.

Optional Feature:
MULTICYCLE_PERF_CNT_EN:
- Defined:
  - perfCycles increments every cycle that reset is low and state is not IDLE/ILLEGAL.
  - perfInstrs increments on each transition back into FETCH from a non-IDLE state.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: both ports tied to 32'b0 and no counter flops are built.

Test Plan:
- Reset held 3 cycles, then released with RESET_PC_HOLD=1 → all outputs 0 during reset and IDLE; FETCH on cycle 2 with IRWrite=1, pcEn=1, ALUSrcB=01.
- lw (opcode 100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; memToReg=1 and regWriteEnable=1 only in cycle 5. sw (101011) → memWrite=1 only in cycle 4, IorD=1.
- R-type sub (funct 100010) → ALUControl=00110 in RTYPE_EX and RTYPE_WB; regDst=1 and regWriteEnable=1 in cycle 4.
- beq with zero=1 → pcEn=1, PCSrc=01 in cycle 3. With zero=0 → pcEn=0; next FETCH follows.
- jr (000000/001000) → jumpReg=1, PCSrc=10, pcEn=1 in cycle 3. Opcode 111111 → ILLEGAL, illegal=1 held 10 cycles, cleared only by reset.
- With MULTICYCLE_PERF_CNT_EN: run lw, add, beq → perfInstrs=3 and perfCycles=12. Reset asserted mid-MEMRD → both counters 0 next cycle and no memWrite/regWriteEnable pulse.
